// File: rtl/mar_nibble_if.sv
// Controller-to-writer bus: address handshake, abort/status, and the MAR pin group.
interface mar_nibble_if #(
  parameter int AW = 16
);
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr;
  logic          abort;
  logic          busy;
  logic          done;
  logic [3:0]    mar_d;
  logic [1:0]    mar_sel;
  logic          mar_g;
  logic          mar_g1_n;
  logic          mar_g2_n;

  modport master (
    output addr_valid, addr, abort,
    input  addr_ready, busy, done, mar_d, mar_sel, mar_g, mar_g1_n, mar_g2_n
  );

  modport slave (
    input  addr_valid, addr, abort,
    output addr_ready, busy, done, mar_d, mar_sel, mar_g, mar_g1_n, mar_g2_n
  );
endinterface

// File: rtl/mar_nibble_writer.sv
// Loads a captured address word into the MAR one nibble at a time, LSB first,
// with a setup / strobe / hold sequence per nibble and a one-cycle done pulse.
module mar_nibble_writer #(
  parameter int NIBBLES       = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  mar_nibble_if.slave  bus
);
  localparam int AW    = 4 * NIBBLES;
  localparam int MAXC0 = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAXC  = (MAXC0 > HOLD_CYCLES) ? MAXC0 : HOLD_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    K_LAST    = 2'(NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    k_q, k_d;
  logic [AW-1:0] shadow_q, shadow_d;
  logic [3:0]    mar_d_q, mar_d_d;
  logic [1:0]    mar_sel_q, mar_sel_d;
  logic          mar_g_q, mar_g_d;
  logic          en_n_q, en_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          addr_ready_w;
  logic          in_xfer;
  logic [15:0]   shadow_ext;

  assign addr_ready_w = (state_q == S_IDLE) && ena;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.addr_valid && addr_ready_w) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          k_d      = 2'd0;
          shadow_d = bus.addr;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            k_d     = k_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every in-flight state; IDLE has nothing to cancel, so accept wins there.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Registered outputs are derived from the next state so pins line up with the state cycle.
  always_comb begin
    in_xfer    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    shadow_ext = 16'(shadow_d);
    mar_d_d    = mar_d_q;
    mar_sel_d  = mar_sel_q;
    if (state_d == S_SETUP) begin
      mar_d_d   = shadow_ext[{k_d, 2'b00} +: 4];
      mar_sel_d = k_d;
    end
    mar_g_d = (state_d == S_STROBE);
    en_n_d  = !in_xfer;
    busy_d  = in_xfer;
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= 2'd0;
      shadow_q  <= '0;
      mar_d_q   <= 4'd0;
      mar_sel_q <= 2'd0;
      mar_g_q   <= 1'b0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      shadow_q  <= shadow_d;
      mar_d_q   <= mar_d_d;
      mar_sel_q <= mar_sel_d;
      mar_g_q   <= mar_g_d;
      en_n_q    <= en_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.addr_ready = addr_ready_w;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mar_d      = mar_d_q;
  assign bus.mar_sel    = mar_sel_q;
  assign bus.mar_g      = mar_g_q;
  assign bus.mar_g1_n   = en_n_q;
  assign bus.mar_g2_n   = en_n_q;
endmodule
